// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JALR   = 2'b10,
        PCSRC_TRAP   = 2'b11
    } pcsrc_t;

    // Low address bits that must be zero for a word-aligned fetch target.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: Decode-stage PC, PC+step and valid bit.
// Priority is rst > flush > stall > load; a flush leaves the PC fields untouched.
module if_id_reg
    import pc_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_pc_plus,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus,
    output logic                o_valid
);

    logic [PC_WIDTH-1:0] r_pc_d;
    logic [PC_WIDTH-1:0] r_pc_plus_d;
    logic                r_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_d      <= '0;
            r_pc_plus_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (i_flush) begin
            r_valid_d   <= 1'b0;
        end else if (!i_stall) begin
            r_pc_d      <= i_pc;
            r_pc_plus_d <= i_pc_plus;
            r_valid_d   <= 1'b1;
        end
    end

    assign o_pc      = r_pc_d;
    assign o_pc_plus = r_pc_plus_d;
    assign o_valid   = r_valid_d;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: PC_F register, next-PC mux with Execute redirects, IF/ID register.
// Optional PC_MISALIGN_TRAP_EN diverts misaligned BRANCH/JALR targets to TrapVec.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  PC_STEP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Stall_F,
    input  logic                Stall_D,
    input  logic                Flush_D,
    input  logic [1:0]          PCSrc_E,
    input  logic [PC_WIDTH-1:0] PC_E,
    input  logic [PC_WIDTH-1:0] ImmExt_E,
    input  logic [PC_WIDTH-1:0] RS1_E,
    input  logic [PC_WIDTH-1:0] TrapVec,
    output logic [PC_WIDTH-1:0] PC_F,
    output logic [PC_WIDTH-1:0] PC_Plus_F,
    output logic [PC_WIDTH-1:0] PC_D,
    output logic [PC_WIDTH-1:0] PC_Plus_D,
    output logic                Valid_D,
    output logic                Misalign_E,
    output logic [PC_WIDTH-1:0] Misalign_Addr
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK_W = PC_WIDTH'(PC_ALIGN_MASK);
    localparam logic [PC_WIDTH-1:0] JALR_MASK_W  = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] r_pc_f;
    logic [PC_WIDTH-1:0] w_pc_plus_f;
    logic [PC_WIDTH-1:0] w_branch_tgt;
    logic [PC_WIDTH-1:0] w_jalr_tgt;
    logic [PC_WIDTH-1:0] w_raw_tgt;
    logic [PC_WIDTH-1:0] w_next_pc;
    pcsrc_t              w_src;
    logic                w_redirect;
    logic                w_checked;

    assign w_src        = pcsrc_t'(PCSrc_E);
    assign w_redirect   = (w_src != PCSRC_SEQ);
    assign w_checked    = (w_src == PCSRC_BRANCH) || (w_src == PCSRC_JALR);
    assign w_pc_plus_f  = r_pc_f + PC_WIDTH'(PC_STEP);
    assign w_branch_tgt = PC_E + ImmExt_E;
    assign w_jalr_tgt   = (RS1_E + ImmExt_E) & ~JALR_MASK_W;

    always_comb begin
        w_raw_tgt = w_pc_plus_f;
        case (w_src)
            PCSRC_SEQ:    w_raw_tgt = w_pc_plus_f;
            PCSRC_BRANCH: w_raw_tgt = w_branch_tgt;
            PCSRC_JALR:   w_raw_tgt = w_jalr_tgt;
            PCSRC_TRAP:   w_raw_tgt = TrapVec;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic                w_misalign;
    logic                r_misalign_e;
    logic [PC_WIDTH-1:0] r_misalign_addr;

    assign w_misalign = w_checked && ((w_raw_tgt & ALIGN_MASK_W) != '0);
    assign w_next_pc  = w_misalign ? TrapVec : w_raw_tgt;

    // Redirects are never blocked by Stall_F, so a misaligned target always traps this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_e    <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_e <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= w_raw_tgt;
            end
        end
    end

    assign Misalign_E    = r_misalign_e;
    assign Misalign_Addr = r_misalign_addr;
`else
    assign w_next_pc     = w_checked ? (w_raw_tgt & ~ALIGN_MASK_W) : w_raw_tgt;
    assign Misalign_E    = 1'b0;
    assign Misalign_Addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f <= RESET_VECTOR;
        end else if (w_redirect) begin
            r_pc_f <= w_next_pc;
        end else if (!Stall_F) begin
            r_pc_f <= w_pc_plus_f;
        end
    end

    assign PC_F      = r_pc_f;
    assign PC_Plus_F = w_pc_plus_f;

    if_id_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (Stall_D),
        .i_flush   (Flush_D),
        .i_pc      (r_pc_f),
        .i_pc_plus (w_pc_plus_f),
        .o_pc      (PC_D),
        .o_pc_plus (PC_Plus_D),
        .o_valid   (Valid_D)
    );

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-stage program-counter unit for the pipelined RV32 core.
- Holds PC_F, computes the sequential and redirect next-PC, and owns the IF/ID register (PC_D, PC_Plus_D, Valid_D).
- Supports hazard stall, ID flush, branch/JAL, JALR and trap redirects resolved in Execute.
- Replaces the single-cycle PC block.

Parameters:
- PC_WIDTH, 32, width of every address port and register.
- RESET_VECTOR, 32'h0000_0000, value loaded into PC_F on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- Stall_F  input  1  hold PC_F.
- Stall_D  input  1  hold the IF/ID register.
- Flush_D  input  1  load a bubble into IF/ID.
- PCSrc_E  input  2  redirect select (pcsrc_t): 00 SEQ, 01 BRANCH, 10 JALR, 11 TRAP.
- PC_E  input  PC_WIDTH  PC of the Execute-stage instruction.
- ImmExt_E  input  PC_WIDTH  sign-extended immediate.
- RS1_E  input  PC_WIDTH  forwarded rs1 value for JALR.
- TrapVec  input  PC_WIDTH  trap handler address.
- PC_F  output  PC_WIDTH  current fetch address.
- PC_Plus_F  output  PC_WIDTH  PC_F + PC_STEP (combinational).
- PC_D  output  PC_WIDTH  Decode-stage PC.
- PC_Plus_D  output  PC_WIDTH  Decode-stage PC + PC_STEP.
- Valid_D  output  1  Decode-stage instruction is real (0 means bubble).
- Misalign_E  output  1  misaligned redirect flag (PC_MISALIGN_TRAP_EN only).
- Misalign_Addr  output  PC_WIDTH  offending target (PC_MISALIGN_TRAP_EN only).

Behaviour:
- Reset, synchronous on posedge clk while rst=1:
  - PC_F=RESET_VECTOR; PC_D=0; PC_Plus_D=0; Valid_D=0; Misalign_E=0; Misalign_Addr=0.
  - rst overrides all other inputs, including mid-redirect.
- Target computation, all arithmetic modulo 2^PC_WIDTH (wrap-around, no carry out):
  - BRANCH: PC_E + ImmExt_E.
  - JALR: (RS1_E + ImmExt_E) with bit0 cleared.
  - TRAP: TrapVec.
  - SEQ: PC_Plus_F.
- PC_F update, priority rst > redirect (PCSrc_E != SEQ) > Stall_F > sequential:
  - A redirect loads the target even when Stall_F=1.
  - Stall_F=1 with PCSrc_E=SEQ: PC_F unchanged.
- IF/ID update, priority rst > Flush_D > Stall_D > load:
  - Flush_D: Valid_D=0; PC_D and PC_Plus_D keep their old values.
  - Load: PC_D=PC_F, PC_Plus_D=PC_Plus_F, Valid_D=1.
  - Flush_D=1 with Stall_D=1: flush wins.
- Latency:
  - A redirect presented in cycle N appears on PC_F in cycle N+1.
  - It appears on PC_D in cycle N+2 unless stalled or flushed.
- First cycle after reset release: PC_F=RESET_VECTOR, Valid_D=0. One cycle later: Valid_D=1, PC_D=RESET_VECTOR.
- No internal state machine beyond the registers. The controller asserts Flush_D on a taken redirect; this block does not infer the flush.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - If a BRANCH or JALR target has bits[1:0] != 0, PC_F loads TrapVec instead of the target.
  - Misalign_E pulses high for exactly 1 cycle (the cycle PC_F=TrapVec).
  - Misalign_Addr registers the unmasked target and holds it until the next misalign or rst.
  - TRAP and SEQ are never checked.
- Undefined:
  - Target bits[1:0] are forced to 0 and loaded.
  - Misalign_E and Misalign_Addr are tied to 0.

Decomposition:
- Package pc_pkg:
  - typedef enum logic [1:0] pcsrc_t {PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JALR, PCSRC_TRAP}.
  - localparam PC_ALIGN_MASK.
- Sub-module if_id_reg: parametrised on PC_WIDTH; holds PC_D, PC_Plus_D and Valid_D with stall/flush priority.
- Next-PC mux and target adders stay in pc_fetch_unit.

Test Plan:
- Reset/sequential: rst for 2 cycles, release, 4 cycles idle -> PC_F 0,4,8,12; PC_D lags PC_F by 1 cycle; Valid_D 0 then 1.
- Stall: Stall_F=Stall_D=1 for 3 cycles with PC_F=0x10 -> PC_F=0x10 and PC_D=0x0C held; resumes at 0x14.
- Branch + flush: PC_E=0x20, ImmExt_E=0xFFFF_FFF0, PCSrc_E=BRANCH, Flush_D=1 -> next PC_F=0x10, Valid_D=0; a simultaneous Stall_F=1 is ignored.
- JALR: RS1_E=0x101, ImmExt_E=4, PCSrc_E=JALR -> PC_F=0x104. With PC_MISALIGN_TRAP_EN, RS1_E=0x102 and TrapVec=0x80 -> PC_F=0x80, Misalign_E=1 for 1 cycle, Misalign_Addr=0x106.
- Wrap: PC_E=0xFFFF_FFFC, ImmExt_E=8, BRANCH -> PC_F=0x4. Sequential from 0xFFFF_FFFC -> 0x0.
- Reset mid-redirect: rst=1 with PCSrc_E=TRAP -> PC_F=RESET_VECTOR, Valid_D=0.
